// File: rtl/viterbi_decoder.sv
// viterbi_decoder: soft-input K=7 r=1/2 (G1=0x4F, G2=0x6D) register-exchange Viterbi decoder.
// Define VITERBI_DEBUG_EN to expose the state-0 path metric on sm_0_debug.
module viterbi_decoder #(
   parameter int TB_DEPTH  = 32,
   parameter int METRIC_W  = 20,
   parameter int INIT_BIAS = 4096
) (
   input  logic                clk,
   input  logic                sys_rst,
   input  logic [7:0]          soft_inp,
   input  logic                valid_in_vit,
   output logic                ready_in,
   output logic                vit_desc,
   output logic                valid_out_vit,
   output logic                normalization,
   output logic [METRIC_W-1:0] sm_0_debug
);
   localparam int FW = $clog2(TB_DEPTH + 1);
   localparam logic [6:0] G1 = 7'h4F;
   localparam logic [6:0] G2 = 7'h6D;
   localparam logic [METRIC_W-1:0] HALF = METRIC_W'(1) << (METRIC_W - 2);
   logic                phase_q, acs_q, ready_q, desc_q, vout_q, norm_q, norm_d, acs;
   logic [7:0]          g1_q;
   logic [FW-1:0]       fill_q;
   logic [5:0]          best;
   logic [METRIC_W-1:0] metric_q [64];
   logic [METRIC_W-1:0] metric_d [64];
   logic [METRIC_W-1:0] c0 [64];
   logic [METRIC_W-1:0] c1 [64];
   logic [TB_DEPTH-1:0] surv_q [64];
   logic [TB_DEPTH-1:0] surv_d [64];
   logic [TB_DEPTH-1:0] win [64];
   // Cost of a symbol is its distance from the expected extreme; flipping all bits swaps e=0/e=1.
   function automatic logic [8:0] bm(input logic [6:0] sr, input logic [7:0] a, input logic [7:0] b);
      logic [7:0] ca, cb;
      ca = (a ^ 8'h80) ^ {8{^(sr & G1)}};
      cb = (b ^ 8'h80) ^ {8{^(sr & G2)}};
      return {1'b0, ca} + {1'b0, cb};
   endfunction
   assign acs = valid_in_vit && ready_q && phase_q;
   always_comb begin
      norm_d = 1'b0;
      for (int n = 0; n < 64; n++) begin
         c0[n] = metric_q[6'(2 * n)] + METRIC_W'(bm(7'(2 * n), g1_q, soft_inp));
         c1[n] = metric_q[6'(2 * n + 1)] + METRIC_W'(bm(7'(2 * n + 1), g1_q, soft_inp));
         metric_d[n] = c1[n] < c0[n] ? c1[n] : c0[n];
         win[n] = c1[n] < c0[n] ? surv_q[6'(2 * n + 1)] : surv_q[6'(2 * n)];
         surv_d[n] = {win[n][TB_DEPTH-2:0], 1'(n >> 5)};
         norm_d = norm_d | metric_d[n][METRIC_W-1];
      end
      for (int n = 0; n < 64; n++)
         metric_d[n] = metric_d[n] - (norm_d ? HALF : '0);
   end
   always_comb begin
      best = '0;
      for (int n = 1; n < 64; n++)
         if (metric_q[n] < metric_q[best]) best = 6'(n);
   end
   always_ff @(posedge clk) begin
      if (sys_rst) begin
         phase_q <= 1'b0;
         acs_q   <= 1'b0;
         ready_q <= 1'b0;
         desc_q  <= 1'b0;
         vout_q  <= 1'b0;
         norm_q  <= 1'b0;
         g1_q    <= '0;
         fill_q  <= '0;
         for (int n = 0; n < 64; n++) begin
            metric_q[n] <= n == 0 ? '0 : METRIC_W'(INIT_BIAS);
            surv_q[n]   <= '0;
         end
      end else begin
         ready_q <= 1'b1;
         acs_q   <= acs;
         norm_q  <= acs && norm_d;
         vout_q  <= acs_q && fill_q == FW'(TB_DEPTH);
         if (acs_q) desc_q <= surv_q[best][TB_DEPTH-1];
         if (valid_in_vit && ready_q) phase_q <= !phase_q;
         if (valid_in_vit && ready_q && !phase_q) g1_q <= soft_inp;
         if (acs) begin
            metric_q <= metric_d;
            surv_q   <= surv_d;
            if (fill_q != FW'(TB_DEPTH)) fill_q <= fill_q + 1'b1;
         end
      end
   end
   assign ready_in      = ready_q;
   assign vit_desc      = desc_q;
   assign valid_out_vit = vout_q;
   assign normalization = norm_q;
`ifdef VITERBI_DEBUG_EN
   assign sm_0_debug = metric_q[0];
`else
   assign sm_0_debug = '0;
`endif
endmodule

// File: tb/tb_viterbi_decoder.sv
// tb_viterbi_decoder: cycle-by-cycle comparison of viterbi_decoder against an integer Viterbi model.
module tb_viterbi_decoder;
   localparam int TB_DEPTH = 32;
   localparam int METRIC_W = 20;
   logic clk = 1'b0, sys_rst = 1'b1, valid_in_vit = 1'b0;
   logic [7:0] soft_inp = '0;
   logic ready_in, vit_desc, valid_out_vit, normalization;
   logic [METRIC_W-1:0] sm_0_debug;
   int n_vec = 0, n_err = 0, vcnt = 0, ncnt = 0;
   bit chk_en = 1'b0;
   bit dec [$];
   logic [7:0] syms [$];
   logic [63:0] pat = 64'hA5C3_0F1E_7788_1234;
   int m [64], nm [64];
   longint unsigned h [64], nh [64];
   int fill;
   bit phase, ready_m, pend, acc;
   logic [7:0] g1s;
   bit exp_ready, exp_valid, exp_norm, exp_desc;
   logic [METRIC_W-1:0] exp_sm0;

   viterbi_decoder #(.TB_DEPTH(TB_DEPTH), .METRIC_W(METRIC_W), .INIT_BIAS(4096)) dut (
      .clk(clk), .sys_rst(sys_rst), .soft_inp(soft_inp), .valid_in_vit(valid_in_vit),
      .ready_in(ready_in), .vit_desc(vit_desc), .valid_out_vit(valid_out_vit),
      .normalization(normalization), .sm_0_debug(sm_0_debug));

   always #5 clk = ~clk;

   function automatic int cost(bit e, logic [7:0] s);
      int v;
      v = int'($signed(s));
      return e ? 127 - v : v + 128;
   endfunction

   function void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic model_acs(input logic [7:0] a, input logic [7:0] b);
      bit any;
      for (int n = 0; n < 64; n++) nm[n] = 32'h7FFF_FFFF;
      for (int p = 0; p < 64; p++)
         for (int bit_v = 0; bit_v < 2; bit_v++) begin
            logic [6:0] sr;
            int n, c;
            sr = 7'(bit_v * 64 + p);
            n = bit_v * 32 + p / 2;
            c = m[p] + cost(^(sr & 7'h4F), a) + cost(^(sr & 7'h6D), b);
            if (c < nm[n]) begin
               nm[n] = c;
               nh[n] = (h[p] << 1) | longint'(bit_v);
            end
         end
      any = 1'b0;
      for (int n = 0; n < 64; n++) if (nm[n] >= (1 << (METRIC_W - 1))) any = 1'b1;
      for (int n = 0; n < 64; n++) begin
         m[n] = any ? nm[n] - (1 << (METRIC_W - 2)) : nm[n];
         h[n] = nh[n];
      end
      exp_norm = any;
      if (fill < TB_DEPTH) fill++;
   endtask

   always @(posedge clk) begin
      if (sys_rst) begin
         for (int n = 0; n < 64; n++) begin
            m[n] = n == 0 ? 0 : 4096;
            h[n] = 0;
         end
         fill = 0; phase = 0; pend = 0; ready_m = 0;
         exp_ready = 0; exp_valid = 0; exp_norm = 0; exp_desc = 0;
      end else begin
         acc = valid_in_vit && ready_m;
         exp_valid = 0;
         exp_norm = 0;
         if (pend) begin
            int b;
            b = 0;
            for (int n = 1; n < 64; n++) if (m[n] < m[b]) b = n;
            exp_desc = bit'((h[b] >> (TB_DEPTH - 1)) & 1);
            exp_valid = fill == TB_DEPTH;
            pend = 0;
         end
         if (acc) begin
            if (!phase) begin
               g1s = soft_inp;
               phase = 1;
            end else begin
               model_acs(g1s, soft_inp);
               phase = 0;
               pend = 1;
            end
         end
         ready_m = 1;
         exp_ready = 1;
      end
`ifdef VITERBI_DEBUG_EN
      exp_sm0 = METRIC_W'(m[0]);
`else
      exp_sm0 = '0;
`endif
   end

   always @(negedge clk) if (chk_en) begin
      chk("ready_in", 64'(ready_in), 64'(exp_ready));
      chk("valid_out_vit", 64'(valid_out_vit), 64'(exp_valid));
      chk("normalization", 64'(normalization), 64'(exp_norm));
      chk("sm_0_debug", 64'(sm_0_debug), 64'(exp_sm0));
      if (exp_valid) chk("vit_desc", 64'(vit_desc), 64'(exp_desc));
      if (valid_out_vit) begin
         dec.push_back(vit_desc);
         vcnt++;
      end
      if (normalization) ncnt++;
   end

   task automatic do_reset();
      sys_rst = 1'b1;
      valid_in_vit = 1'b0;
      repeat (2) @(negedge clk);
      sys_rst = 1'b0;
      @(negedge clk);
      dec.delete();
      vcnt = 0;
      ncnt = 0;
   endtask

   task automatic send(input logic [7:0] s, input int gap);
      repeat (gap) begin
         valid_in_vit = 1'b0;
         @(negedge clk);
      end
      valid_in_vit = 1'b1;
      soft_inp = s;
      @(negedge clk);
      valid_in_vit = 1'b0;
   endtask

   task automatic build_msg();
      logic [5:0] st;
      logic [6:0] sr;
      bit b;
      st = '0;
      syms.delete();
      for (int i = 0; i < 96; i++) begin
         b = i < 64 ? pat[63 - i] : 1'b0;
         sr = {b, st};
         syms.push_back(^(sr & 7'h4F) ? 8'd127 : 8'h81);
         syms.push_back(^(sr & 7'h6D) ? 8'd127 : 8'h81);
         st = sr[6:1];
      end
   endtask

   task automatic run_msg(input int mode, input string name);
      logic [63:0] got;
      logic [7:0] s;
      do_reset();
      for (int i = 0; i < syms.size(); i++) begin
         s = syms[i];
         if (mode == 1 && (i == 10 || i == 11 || i == 50)) s = -s;
         send(s, mode == 2 ? int'($urandom_range(0, 3)) : 0);
      end
      repeat (3) @(negedge clk);
      chk({name, "_valid_cnt"}, 64'(vcnt), 64'd65);
      got = '0;
      for (int i = 0; i < 64 && i < dec.size(); i++) got[63 - i] = dec[i];
      chk({name, "_bits"}, got, pat);
   endtask

   initial begin
      int ones;
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, vectors %0d", n_vec);
      $fatal(1, "timeout");
   end

   initial begin
      int ones;
      @(negedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_ready_in", 64'(ready_in), 64'd0);
      chk("rst_valid_out", 64'(valid_out_vit), 64'd0);
      chk("rst_norm", 64'(normalization), 64'd0);
      chk("rst_sm0", 64'(sm_0_debug), 64'd0);
      chk("rst_desc", 64'(vit_desc), 64'd0);
      sys_rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", 64'(ready_in), 64'd1);
      chk("cost_1_p127", 64'(cost(1'b1, 8'd127)), 64'd0);
      chk("cost_0_m128", 64'(cost(1'b0, 8'h80)), 64'd0);
      chk("cost_1_m128", 64'(cost(1'b1, 8'h80)), 64'd255);
      chk("cost_0_p127", 64'(cost(1'b0, 8'd127)), 64'd255);
      do_reset();
      repeat (2 * TB_DEPTH + 20) send(8'h80, 0);
      repeat (3) @(negedge clk);
      chk("zero_valid_cnt", 64'(vcnt), 64'd11);
      ones = 0;
      foreach (dec[i]) ones += int'(dec[i]);
      chk("zero_bits", 64'(ones), 64'd0);
      chk("zero_sm0", 64'(sm_0_debug), 64'd0);
      build_msg();
      run_msg(0, "msg");
      run_msg(1, "errcorr");
      run_msg(2, "flow");
      do_reset();
      for (int i = 0; i < 10000; i++) send(8'($urandom), 0);
      repeat (3) @(negedge clk);
      chk("long_valid_cnt", 64'(vcnt), 64'(5000 - TB_DEPTH + 1));
      chk("long_norm_seen", 64'(ncnt > 0), 64'd1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
